// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Owns the PC register and fetches one instruction at a time from
// instruction memory over a req/gnt/rvalid handshake. The returned word is
// held, together with its PC and decoded fields, until the execute side
// acknowledges it. The next PC is then either sequential or the supplied
// branch/jump target. A misaligned taken target parks the unit in a terminal
// error state until reset.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   fetch_en               permits new fetch requests
//   imem_req/imem_addr     request and word-aligned address to memory
//   imem_gnt               memory accepts the request this cycle
//   imem_rvalid/imem_rdata returned instruction word
//   instr_valid/instr      held instruction and its valid flag
//   op/funct3/funct7b5     decoded fields of the held instruction
//   pc/pc_plus4            PC of the held instruction and PC + 4
//   instr_ack              execute side retires the held instruction
//   PCSrc/PCTarget         take PCTarget instead of pc_plus4 on ack
//   fetch_err              sticky misaligned-target error
//   instret                retired-instruction counter (wraps)
module fetch_unit #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            instr_ack,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            fetch_err,
  output logic [31:0]     instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            fetch_err_q;
  logic [31:0]     instret_q;

  logic            ack_take;
  logic            target_misaligned;
  logic            capture;

  // An ack only counts while an instruction is actually held.
  assign ack_take          = (state_q == HOLD) && instr_ack;
  assign target_misaligned = PCSrc && (PCTarget[1:0] != 2'b00);
  // Data is captured only in WAIT, so a stray rvalid after an aborted
  // transaction (e.g. across a reset) can never reach instr.
  assign capture           = (state_q == WAIT) && imem_rvalid;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch_en) state_d = REQ;
      // No retraction: once raised, the request waits for gnt regardless
      // of fetch_en.
      REQ:  if (imem_gnt) state_d = WAIT;
      WAIT: if (imem_rvalid) state_d = HOLD;
      HOLD: begin
        if (instr_ack) begin
          if (target_misaligned) state_d = ERR;
          else if (fetch_en)     state_d = REQ;
          else                   state_d = IDLE;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // PC, held instruction, error flag and retire counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= XLEN'(RESET_PC);
      instr_q     <= NOP;
      fetch_err_q <= 1'b0;
      instret_q   <= 32'd0;
    end else begin
      if (capture) instr_q <= imem_rdata;
      if (ack_take) begin
        // The acked instruction itself retires even if its target faults.
        instret_q <= instret_q + 32'd1;
        if (target_misaligned) fetch_err_q <= 1'b1;
        else                   pc_q        <= PCSrc ? PCTarget : pc_plus4;
      end
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7b5    = instr_q[30];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign fetch_err   = fetch_err_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        fetch_err;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_instret = 32'd0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .pc(pc), .pc_plus4(pc_plus4),
    .instr_ack(instr_ack), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .fetch_err(fetch_err), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Serve one fetch with zero-wait memory: gnt in the first REQ cycle,
  // rvalid the cycle after. ok=0 if no request appears within the budget.
  task automatic do_fetch(input logic [31:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) break;
      step();
    end
    if (!imem_req) return;
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    ok = 1'b1;
  endtask

  task automatic do_ack(input logic src, input logic [31:0] tgt);
    instr_ack = 1'b1;
    PCSrc     = src;
    PCTarget  = tgt;
    step();
    instr_ack = 1'b0;
    PCSrc     = 1'b0;
    PCTarget  = 32'h0;
  endtask

  task automatic test_reset;
    reset_n = 1'b1; fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; instr_ack = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
    #2 reset_n = 1'b0;
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", instr_valid); end
    total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h want=00000013", instr); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=00000000", pc); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc_plus4 got=%h want=00000004", pc_plus4); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", fetch_err); end
    total++; if (instret !== 32'h0) begin bad++; $display("FAIL reset_instret got=%h want=0", instret); end
  endtask

  task automatic test_first_fetch;
    bit ok;
    fetch_en = 1'b1;
    reset_n  = 1'b1;
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0b want=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h want=00000000", imem_addr); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL first_wait_req got=%0b want=0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b want=1", instr_valid); end
    total++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL first_instr got=%h want=00500093", instr); end
    total++; if (op !== 7'h13 || funct3 !== 3'd0 || funct7b5 !== 1'b0)
      begin bad++; $display("FAIL first_decode got=%h/%0d/%0b want=13/0/0", op, funct3, funct7b5); end
    // Hold stays stable while no ack arrives.
    step(); step();
    total++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || pc !== 32'h0)
      begin bad++; $display("FAIL hold_stable got=%0b/%h/%h want=1/00500093/0", instr_valid, instr, pc); end
    ok = 1'b1;
  endtask

  task automatic test_seq_ack;
    bit ok;
    do_ack(1'b1, 32'h10); exp_instret++;
    do_fetch(32'h4020_8033, ok);
    total++; if (!ok) begin bad++; $display("FAIL seq_fetch_timeout got=0 want=1"); end
    total++; if (pc !== 32'h10 || op !== 7'h33 || funct7b5 !== 1'b1)
      begin bad++; $display("FAIL seq_hold got=%h/%h/%0b want=10/33/1", pc, op, funct7b5); end
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL seq_instret0 got=%h want=%h", instret, exp_instret); end
    do_ack(1'b0, 32'hDEAD_BEE0); exp_instret++;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL seq_gap_req got=%0b want=1", imem_req); end
    total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL seq_addr got=%h want=00000014", imem_addr); end
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL seq_instret1 got=%h want=%h", instret, exp_instret); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_valid_drop got=%0b want=0", instr_valid); end
  endtask

  task automatic test_branch;
    bit ok;
    do_fetch(32'h00C0_00EF, ok);
    total++; if (!ok || op !== 7'h6F || pc !== 32'h14)
      begin bad++; $display("FAIL br_hold got=%0b/%h/%h want=1/6f/14", ok, op, pc); end
    do_ack(1'b1, 32'h40); exp_instret++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
      begin bad++; $display("FAIL br_addr got=%0b/%h want=1/00000040", imem_req, imem_addr); end
  endtask

  task automatic test_gnt_stall;
    bit ok;
    // Already in REQ at 0x40; withhold gnt for 5 cycles, drop fetch_en in cycle 2.
    for (int i = 0; i < 5; i++) begin
      if (i == 1) fetch_en = 1'b0;
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
        begin bad++; $display("FAIL stall_hold%0d got=%0b/%h want=1/00000040", i, imem_req, imem_addr); end
    end
    do_fetch(32'h0000_2003, ok);
    total++; if (!ok || instr_valid !== 1'b1 || funct3 !== 3'd2 || op !== 7'h03)
      begin bad++; $display("FAIL stall_fetch got=%0b/%0d/%h want=1/2/03", instr_valid, funct3, op); end
    do_ack(1'b0, 32'h0); exp_instret++;
    step(); step();
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h44)
      begin bad++; $display("FAIL stall_idle got=%0b/%0b/%h want=0/0/44", imem_req, instr_valid, pc); end
    fetch_en = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h44)
      begin bad++; $display("FAIL stall_resume got=%0b/%h want=1/00000044", imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    bit ok;
    do_fetch(32'h0000_0013, ok);
    do_ack(1'b1, 32'hFFFF_FFFC); exp_instret++;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h want=fffffffc", imem_addr); end
    do_fetch(32'h0000_0013, ok);
    total++; if (!ok || pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc_plus4 got=%h want=00000000", pc_plus4); end
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    do_ack(1'b0, 32'h0);
    exp_instret = 32'h0;
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL wrap_instret got=%h want=00000000", instret); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin bad++; $display("FAIL wrap_next got=%0b/%h want=1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_misaligned;
    bit ok;
    do_fetch(32'h0000_0063, ok);
    total++; if (!ok || pc !== 32'h0) begin bad++; $display("FAIL mis_hold got=%0b/%h want=1/0", ok, pc); end
    do_ack(1'b1, 32'h42);
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%0b want=1", fetch_err); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL mis_pc got=%h want=00000000", pc); end
    for (int i = 0; i < 4; i++) begin
      instr_ack = 1'b1;
      step();
      total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1)
        begin bad++; $display("FAIL mis_err_state%0d got=%0b/%0b/%0b want=0/0/1", i, imem_req, instr_valid, fetch_err); end
    end
    instr_ack = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    // Clear ERR, then start a fetch and abort it in WAIT.
    #2 reset_n = 1'b0;
    step();
    reset_n  = 1'b1;
    fetch_en = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || fetch_err !== 1'b0)
      begin bad++; $display("FAIL rw_req got=%0b/%0b want=1/0", imem_req, fetch_err); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    fetch_en = 1'b0;
    #2 reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0033;
    step(); step();
    imem_rvalid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rw_valid got=%0b want=0", instr_valid); end
    total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL rw_instr got=%h want=00000013", instr); end
    total++; if (pc !== 32'h0 || imem_req !== 1'b0 || instret !== 32'h0)
      begin bad++; $display("FAIL rw_state got=%h/%0b/%h want=0/0/0", pc, imem_req, instret); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_seq_ack();
    test_branch();
    test_gnt_stall();
    test_wrap();
    test_misaligned();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
